// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button debounce, start/stop/lap/clear FSM and display select
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [3:0] live_min,
  input  logic [3:0] live_tsec,
  input  logic [3:0] live_osec,
  input  logic [3:0] live_tenth,
  output logic       run,
  output logic       cnt_clr,
  output logic       lap_active,
  output logic [3:0] disp_min,
  output logic [3:0] disp_tsec,
  output logic [3:0] disp_osec,
  output logic [3:0] disp_tenth
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = start/stop, bit 1 = lap, bit 2 = clear.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      stable_q, stable_d;
  logic [2:0]      prev_q, prev_d;
  logic [DB_W-1:0] cnt_q [3];
  logic [DB_W-1:0] cnt_d [3];
  logic [2:0]      press;

  assign btn_raw = {btn_clr, btn_lap, btn_ss};

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level; a held button fires once.
  assign press = stable_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic       ev_ss, ev_lap, ev_clr;
  state_t     state_q, state_d;
  logic       run_q, run_d;
  logic       lap_active_q, lap_active_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic [15:0] lap_q, lap_d;

  assign ev_ss  = press[0];
  assign ev_lap = press[1];
  assign ev_clr = press[2];

  // Each state checks only its own legal events, highest priority first.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    case (state_q)
      IDLE: begin
        if (ev_ss) state_d = RUN;
      end
      RUN: begin
        if (ev_ss) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d = LAP;
          lap_d   = {live_min, live_tsec, live_osec, live_tenth};
        end
      end
      LAP: begin
        if (ev_ss)       state_d = PAUSE;
        else if (ev_lap) state_d = RUN;
      end
      PAUSE: begin
        if (ev_clr)     state_d = IDLE;
        else if (ev_ss) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    run_d        = (state_d == RUN) || (state_d == LAP);
    lap_active_d = (state_d == LAP);
    cnt_clr_d    = (state_q == PAUSE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      lap_active_q <= 1'b0;
      cnt_clr_q    <= 1'b0;
      lap_q        <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      lap_active_q <= lap_active_d;
      cnt_clr_q    <= cnt_clr_d;
      lap_q        <= lap_d;
    end
  end

  assign run        = run_q;
  assign lap_active = lap_active_q;
  assign cnt_clr    = cnt_clr_q;

  always_comb begin
    if (lap_active_q) begin
      {disp_min, disp_tsec, disp_osec, disp_tenth} = lap_q;
    end else begin
      {disp_min, disp_tsec, disp_osec, disp_tenth} =
        {live_min, live_tsec, live_osec, live_tenth};
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end control stage for the stopwatch datapath. It debounces the three board buttons and runs the start/stop/lap/clear state machine. Outputs are the clock-enable for the tenth-second tick timer and the clear for the BCD counter chain. It also captures lap times and selects which four BCD digits the seven-segment display driver shows: live or frozen. It replaces the bare SR latch with a glitch-free, registered controller.

Parameters:
DEBOUNCE_CYCLES, 500000, stable-input cycles needed to accept a button level change (10 ms at 50 MHz)
DB_W, 20, width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-high reset
btn_ss  input  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  input  1  raw lap button, active-high, asynchronous
btn_clr  input  1  raw clear button, active-high, asynchronous
live_min  input  4  live BCD minutes from counter chain
live_tsec  input  4  live BCD tens of seconds
live_osec  input  4  live BCD ones of seconds
live_tenth  input  4  live BCD tenths
run  output  1  clock-enable to tick timer; high while time advances
cnt_clr  output  1  one-cycle clear pulse to counter chain
lap_active  output  1  high while display is frozen on a lap value
disp_min, disp_tsec, disp_osec, disp_tenth  output  4 each  digits to display driver

Behaviour:
- Reset: one clock; rst is asynchronous and active-high; clock port clk, reset port rst. rst forces all registers to their reset values immediately.
- Reset values: state=IDLE, run=0, cnt_clr=0, lap_active=0, lap registers=0, debounce stable levels=0, counters=0, synchronizers=0.
- Reset mid-operation returns to IDLE with no cnt_clr pulse. The counter chain is cleared by its own reset.
- Per button: 2-FF synchronizer, then debounce counter.
  - Counter clears whenever the synced level equals the stable level.
  - Counter increments while the two differ.
  - On reaching DEBOUNCE_CYCLES-1 with the levels still differing, the stable level takes the synced level and the counter clears.
- Press event: one-cycle pulse on the stable level's 0->1 transition. Release generates nothing. Holding a button yields exactly one event.
- Latency: raw edge to press pulse = 2 sync cycles + DEBOUNCE_CYCLES cycles. State and outputs update on the clock edge after the pulse.
- Event priority in the same cycle: clr > ss > lap. Only the highest-priority event valid in the current state is acted on; the others are dropped.
- FSM states: IDLE, RUN, LAP, PAUSE.
  - IDLE: ss -> RUN. lap and clr ignored.
  - RUN: ss -> PAUSE. lap -> LAP and captures live_* into lap registers on that edge. clr ignored.
  - LAP: lap -> RUN (releases the freeze). ss -> PAUSE (releases the freeze). clr ignored.
  - PAUSE: ss -> RUN. clr -> IDLE. lap ignored.
- Outputs are registered (Moore):
  - run=1 in RUN and LAP only.
  - lap_active=1 in LAP only.
  - cnt_clr=1 for exactly the one cycle after the PAUSE->IDLE transition edge, then 0.
- Display select: disp_* = lap registers when in LAP, else live_* passed through combinationally.
- Lap registers hold their value until the next capture or rst. They are not cleared by clr.
- Inputs are not range-checked; non-BCD values pass through unchanged.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert rst mid-RUN -> run=0, lap_active=0, cnt_clr=0 immediately; state IDLE after release.
- Debounce: btn_ss pulses high for 3 cycles, then 0 -> no event, run stays 0. btn_ss held 10 cycles -> run=1 exactly 7 cycles after the raw edge (2 sync + 4 count + 1 state), one event only.
- Start/stop/clear: ss press -> run=1; ss press -> run=0 (PAUSE); clr press -> cnt_clr high exactly 1 cycle, state IDLE.
- Clear while running: clr press in RUN -> ignored, run stays 1, cnt_clr stays 0.
- Lap freeze: in RUN with live=1,2,3,4 (1:23.4), lap press -> disp=1,2,3,4 while live advances to 1,2,5,0. lap_active=1, run=1. Second lap press -> disp tracks live again, lap_active=0.
- Simultaneous events: ss and lap stable edges in the same cycle in RUN -> PAUSE entered, no lap capture. clr+ss together in PAUSE -> IDLE with cnt_clr pulse, run=0.
